// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Shift-add multiply and restoring divide, one bit per cycle, with sign fix-up on completion.
module ex_muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in_1,
    input  logic [XLEN-1:0] in_2,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, MUL_RUN, DIV_RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic            neg_q, neg_d;
    logic            s1_q, s1_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic            idle_or_done, accept, last;
    logic            s1_en, s2_en, s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    logic            div_zero, div_ovf;
    logic [XLEN:0]   mul_sum, div_trial;
    logic [AW-1:0]   mul_acc, div_acc, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign accept       = start && !flush && idle_or_done;
    assign last         = (cnt_q == CW'(XLEN - 1));

    // Operand signedness by funct3: MULHSU signs rs1 only, unsigned ops sign neither.
    assign s1_en = (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
                   (op == 3'b100) || (op == 3'b110);
    assign s2_en = (op == 3'b000) || (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign s1    = s1_en && in_1[XLEN-1];
    assign s2    = s2_en && in_2[XLEN-1];
    assign mag1  = s1 ? -in_1 : in_1;
    assign mag2  = s2 ? -in_2 : in_2;

    assign div_zero = (in_2 == '0);
    assign div_ovf  = !op[0] && (in_1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_2 == '1);

    // Multiply: acc = {partial_hi, multiplier}; add multiplicand on LSB then shift right.
    assign mul_sum = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_acc = {mul_sum, acc_q[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; trial-subtract the shifted remainder.
    assign div_trial = acc_q[AW-1:XLEN-1] - {1'b0, a_q};
    assign div_acc   = div_trial[XLEN] ? {acc_q[AW-2:0], 1'b0}
                                       : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    assign prod_fix = neg_q ? -mul_acc : mul_acc;
    assign quo_fix  = neg_q ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
    assign rem_fix  = s1_q ? -div_acc[AW-1:XLEN] : div_acc[AW-1:XLEN];

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        s1_d        = s1_q;
        result_d    = result_q;
        out_valid_d = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d  = op[1:0];
                    neg_d = s1 ^ s2;
                    s1_d  = s1;
                    cnt_d = '0;
                    if (!op[2]) begin
                        a_d     = mag1;
                        acc_d   = {{XLEN{1'b0}}, mag2};
                        state_d = MUL_RUN;
                    end else if (div_zero) begin
                        result_d    = op[1] ? in_1 : '1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (div_ovf) begin
                        result_d    = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        a_d     = mag2;
                        acc_d   = {{XLEN{1'b0}}, mag1};
                        state_d = DIV_RUN;
                    end
                end
            end
            MUL_RUN: begin
                acc_d = mul_acc;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    result_d    = (op_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[AW-1:XLEN];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DIV_RUN: begin
                acc_d = div_acc;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    result_d    = op_q[1] ? rem_fix : quo_fix;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush kills any operation and leaves the last result untouched.
        if (flush) begin
            state_d     = IDLE;
            result_d    = result_q;
            out_valid_d = 1'b0;
        end

        busy_d = (state_d == MUL_RUN) || (state_d == DIV_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            s1_q        <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            s1_q        <= s1_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Stall while accepting or iterating; low in DONE so the pipeline captures result.
    assign stall     = (start && !flush && idle_or_done) ||
                       (state_q == MUL_RUN) || (state_q == DIV_RUN);
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
endmodule
